// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, slave-index field width, decode-error flag.
package apb_pkg;

  localparam int unsigned IDX_W      = 4;
  localparam logic        DECODE_ERR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decode: 4-bit index field at SEL_LSB -> one-hot select plus out-of-range flag.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_LSB    = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] sel_o_c,
  output logic                  dec_err_o_c
);

  logic [IDX_W-1:0] idx_c;
  logic             unused_addr_c;

  assign idx_c         = addr_i[SEL_LSB +: IDX_W];
  assign unused_addr_c = ^addr_i;

  always_comb begin
    sel_o_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel_o_c[i] = (idx_c == IDX_W'(i));
    end
  end

  assign dec_err_o_c = (32'(idx_c) >= NUM_SLAVES);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP/ACCESS with wait states, single-cycle response.
// Optional ACCESS wait timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SEL_LSB        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  apb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0]  psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [NUM_SLAVES-1:0]  dec_sel_c;
  logic                   dec_err_c;
  logic                   sel_ready_c;
  logic                   sel_err_c;
  logic [DATA_WIDTH-1:0]  sel_rdata_c;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
`else
  logic                   unused_timeout_c;
  assign unused_timeout_c = ^32'(TIMEOUT_CYCLES);
`endif

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB)
  ) u_dec (
    .addr_i      (cmd_addr),
    .sel_o_c     (dec_sel_c),
    .dec_err_o_c (dec_err_c)
  );

  // PSEL is one-hot during a transfer, so it doubles as the return-path mux select.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_err_c   = 1'b0;
    sel_rdata_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel_ready_c = sel_ready_c | (psel_q[i] & PREADY[i]);
      sel_err_c   = sel_err_c | (psel_q[i] & PSLVERR[i]);
      sel_rdata_c = sel_rdata_c | ({DATA_WIDTH{psel_q[i]}} & PRDATA[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          if (dec_err_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = DECODE_ERR;
            rsp_rdata_d = '0;
          end else begin
            psel_d  = dec_sel_c;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready_c) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err_c;
          rsp_rdata_d = (pwrite_q || sel_err_c) ? '0 : sel_rdata_c;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // Ready on the limit edge wins over the abort.
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
